// File: rtl/sar_compare_search_pkg.sv
// sar_compare_search_pkg
//   Shared types for the successive-approximation search engine:
//   FSM state enum and the one-hot check applied to the comparator flags.
package sar_compare_search_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_TRY  = 2'd1,
        S_DONE = 2'd2
    } sar_state_t;

    // A healthy comparator asserts exactly one of agb/asb/aeb.
    function automatic logic onehot3(input logic a, input logic b, input logic c);
        return ({a, b, c} == 3'b100) || ({a, b, c} == 3'b010) || ({a, b, c} == 3'b001);
    endfunction

endpackage

// File: rtl/sar_compare_search.sv
// sar_compare_search
//   Successive-approximation master for a magnitude comparator. On an accepted
//   start it drives probe values onto the comparator B input, reads agb/asb/aeb
//   and binary-searches the comparator A operand, returning it on result.
// Ports
//   clk            rising-edge clock
//   rst            asynchronous active-high reset
//   start          search request, accepted only while idle
//   busy           high from the cycle after start is accepted through the done cycle
//   probe[W-1:0]   registered comparator B operand (0 while idle)
//   agb/asb/aeb    comparator flags: target >, <, == probe
//   result[W-1:0]  search result, held until the next accepted start
//   done           one-cycle pulse when result/err are valid
//   err            inconsistent flags seen during the search, held with result
module sar_compare_search
    import sar_compare_search_pkg::*;
#(
    parameter int unsigned WIDTH  = 4,
    parameter int unsigned SETTLE = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic             busy,
    output logic [WIDTH-1:0] probe,
    input  logic             agb,
    input  logic             asb,
    input  logic             aeb,
    output logic [WIDTH-1:0] result,
    output logic             done,
    output logic             err
);

    localparam int unsigned      BIT_W    = $clog2(WIDTH);
    localparam int unsigned      CNT_W    = (SETTLE > 0) ? $clog2(SETTLE + 1) : 1;
    localparam logic [CNT_W-1:0] SETTLE_C = CNT_W'(SETTLE);
    localparam logic [BIT_W-1:0] MSB_IDX  = BIT_W'(WIDTH - 1);
    localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);

    sar_state_t       state_q, state_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [BIT_W-1:0] bit_idx_q, bit_idx_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] probe_q, probe_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             err_q, err_d;

    logic [WIDTH-1:0] acc_n;
    logic [BIT_W-1:0] bit_n;

    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        bit_idx_d = bit_idx_q;
        cnt_d     = cnt_q;
        probe_d   = probe_q;
        result_d  = result_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        err_d     = err_q;
        // Accumulator after this probe: keep the trial bit only when target > probe.
        acc_n     = agb ? probe_q : acc_q;
        bit_n     = bit_idx_q - 1'b1;

        case (state_q)
            S_IDLE: begin
                probe_d = '0;
                busy_d  = 1'b0;
                if (start) begin
                    acc_d     = '0;
                    bit_idx_d = MSB_IDX;
                    probe_d   = ONE << MSB_IDX;
                    cnt_d     = '0;
                    result_d  = '0;
                    err_d     = 1'b0;
                    busy_d    = 1'b1;
                    state_d   = S_TRY;
                end
            end
            S_TRY: begin
                if (cnt_q != SETTLE_C) begin
                    cnt_d = cnt_q + 1'b1;
                end else if (!onehot3(agb, asb, aeb)) begin
                    err_d    = 1'b1;
                    result_d = acc_q;
                    done_d   = 1'b1;
                    state_d  = S_DONE;
                end else if (aeb) begin
                    result_d = probe_q;
                    done_d   = 1'b1;
                    state_d  = S_DONE;
                end else if (bit_idx_q == '0) begin
                    // agb on the last bit contradicts the earlier answers.
                    acc_d    = acc_n;
                    result_d = acc_n;
                    err_d    = agb;
                    done_d   = 1'b1;
                    state_d  = S_DONE;
                end else begin
                    acc_d     = acc_n;
                    bit_idx_d = bit_n;
                    probe_d   = acc_n | (ONE << bit_n);
                    cnt_d     = '0;
                end
            end
            S_DONE: begin
                busy_d  = 1'b0;
                probe_d = '0;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            acc_q     <= '0;
            bit_idx_q <= '0;
            cnt_q     <= '0;
            probe_q   <= '0;
            result_q  <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            bit_idx_q <= bit_idx_d;
            cnt_q     <= cnt_d;
            probe_q   <= probe_d;
            result_q  <= result_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

    assign busy   = busy_q;
    assign probe  = probe_q;
    assign result = result_q;
    assign done   = done_q;
    assign err    = err_q;

endmodule
